// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: small byte FIFO, programmable bit divisor,
// 8N1 framing with back-to-back frames. Synchronous active-low reset.
module uart_tx_mmio #(
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_RESET  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        tx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
   typedef enum logic [1:0] {A_DATA, A_STATUS, A_DIVISOR, A_RSVD} reg_sel_t;

   state_t        r_state, w_state_next;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overrun;
   logic [15:0]   r_div, r_div_lat, r_cyc, w_cyc_next;
   logic [7:0]    r_shift, w_shift_next;
   logic [2:0]    r_bit_idx, w_bit_idx_next;
   logic          r_tx, w_tx_next;
   logic [31:0]   r_rd, w_rd_next;
   logic [4:0]    w_count5;
   reg_sel_t      w_sel;
   logic          w_full, w_empty, w_pop, w_push, w_bit_end, w_busy;
   logic          w_wr_data, w_wr_status, w_wr_div;
   logic          w_unused;

   assign w_sel       = reg_sel_t'(addr[3:2]);
   assign w_wr_data   = we && (w_sel == A_DATA);
   assign w_wr_status = we && (w_sel == A_STATUS);
   assign w_wr_div    = we && (w_sel == A_DIVISOR);
   assign w_full      = (r_count == CW'(FIFO_DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_bit_end   = (r_cyc == r_div_lat - 16'd1);
   assign w_busy      = (r_state != S_IDLE);
   assign w_count5    = 5'(r_count);
   // A full FIFO still accepts a byte when the transmitter frees a slot this cycle.
   assign w_push      = w_wr_data && (!w_full || w_pop);
   assign w_unused    = ^{addr[31:4], addr[1:0], wd[31:16]};

   always_comb begin
      // NOTE: every comb output gets a default first, so no path can infer a latch.
      w_state_next   = r_state;
      w_pop          = 1'b0;
      w_cyc_next     = r_cyc + 16'd1;
      w_shift_next   = r_shift;
      w_bit_idx_next = r_bit_idx;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_state_next = S_START;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_state_next   = S_DATA;
               w_cyc_next     = '0;
               w_bit_idx_next = '0;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_cyc_next     = '0;
               w_shift_next   = r_shift >> 1;
               w_bit_idx_next = r_bit_idx + 3'd1;
               if (r_bit_idx == 3'd7) w_state_next = S_STOP;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_state_next = S_START;
               end else begin
                  w_state_next = S_IDLE;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
      if (w_pop) begin
         w_cyc_next   = '0;
         w_shift_next = r_mem[r_rd_ptr];
      end
      w_tx_next = (w_state_next == S_DATA) ? w_shift_next[0] : (w_state_next != S_START);
   end

   always_comb begin
      w_rd_next = '0;
      case (w_sel)
         A_STATUS:  w_rd_next = {19'h0, w_count5, 4'h0, r_overrun, w_busy, w_empty, w_full};
         A_DIVISOR: w_rd_next = {16'h0, r_div};
         default:   w_rd_next = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
         r_div     <= 16'(DIV_RESET);
         r_div_lat <= 16'(DIV_RESET);
         r_cyc     <= '0;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_tx      <= 1'b1;
         r_rd      <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (w_wr_data && w_full && !w_pop) r_overrun <= 1'b1;
         else if (w_wr_status && wd[3])     r_overrun <= 1'b0;
         if (w_wr_div) r_div <= (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
         if (w_pop)    r_div_lat <= r_div;
         r_cyc     <= w_cyc_next;
         r_shift   <= w_shift_next;
         r_bit_idx <= w_bit_idx_next;
         r_tx      <= w_tx_next;
         r_rd      <= w_rd_next;
      end
   end

   // NOTE: FIFO storage is not reset; pointers and count alone define valid entries.
   always_ff @(posedge clk) begin
      if (reset && w_push) r_mem[r_wr_ptr] <= wd[7:0];
   end

   assign rd = r_rd;
   assign tx = r_tx;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed scenarios plus random bus
// traffic, all compared cycle by cycle against a frame-level reference model.
module tb_uart_tx_mmio;
   localparam int DEPTH   = 8;
   localparam int DIV_RST = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wd = '0;
   logic [31:0] rd;
   logic        tx;

   uart_tx_mmio #(.FIFO_DEPTH(DEPTH), .DIV_RESET(DIV_RST)) dut (
      .clk  (clk),
      .reset(reset),
      .we   (we),
      .addr (addr),
      .wd   (wd),
      .rd   (rd),
      .tx   (tx)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, obs, exp, $time);
   endtask

   // Reference model: queue of pending bytes plus "position k within the current frame".
   logic [7:0]  m_q[$];
   logic [15:0] m_div = 16'(DIV_RST);
   bit          m_ovr = 1'b0;
   bit          m_act = 1'b0;
   logic [7:0]  m_byte = '0;
   int          m_fdiv = 1;
   int          m_k = 0;
   logic        m_tx = 1'b1;
   logic [31:0] m_rd = '0;

   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx == 9) return 1'b1;
      return b[idx-1];
   endfunction

   task automatic model_step();
      logic [31:0] status;
      logic [1:0]  sel;
      bit          pop, full_pre;
      sel       = addr[3:2];
      full_pre  = (m_q.size() == DEPTH);
      status    = '0;
      status[0] = full_pre;
      status[1] = (m_q.size() == 0);
      status[2] = m_act;
      status[3] = m_ovr;
      status[12:8] = 5'(m_q.size());
      if (!reset) begin
         m_q.delete();
         m_div = 16'(DIV_RST);
         m_ovr = 1'b0;
         m_act = 1'b0;
         m_k   = 0;
         m_rd  = '0;
      end else begin
         m_rd = (sel == 2'd1) ? status : (sel == 2'd2) ? {16'h0, m_div} : 32'h0;
         pop = (m_q.size() > 0) && (!m_act || m_k == 10 * m_fdiv - 1);
         if (pop) begin
            m_byte = m_q.pop_front();
            m_act  = 1'b1;
            m_k    = 0;
            m_fdiv = int'(m_div);
         end else if (m_act) begin
            if (m_k == 10 * m_fdiv - 1) m_act = 1'b0;
            else m_k++;
         end
         if (we && sel == 2'd0) begin
            if (!full_pre || pop) m_q.push_back(wd[7:0]);
            else m_ovr = 1'b1;
         end
         if (we && sel == 2'd1 && wd[3]) m_ovr = 1'b0;
         if (we && sel == 2'd2) m_div = (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
      end
      m_tx = m_act ? frame_bit(m_byte, m_k / m_fdiv) : 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("tx", {31'h0, tx}, {31'h0, m_tx});
      check("rd", rd, m_rd);
   endtask

   task automatic set_addr(input logic [1:0] sel);
      addr = ($urandom() & 32'hFFFF_FFF3) | {28'h0, sel, 2'b00};
   endtask

   task automatic wr(input logic [1:0] sel, input logic [31:0] data);
      we = 1'b1;
      set_addr(sel);
      wd = data;
      tick();
      we = 1'b0;
   endtask

   task automatic rd_reg(input logic [1:0] sel);
      we = 1'b0;
      set_addr(sel);
      tick();
   endtask

   logic [9:0]  pat;
   logic [19:0] pat2;
   logic [1:0]  rsel;

   initial begin
      // Reset held for three cycles, with bus writes that must be ignored.
      reset = 1'b0;
      we = 1'b1; set_addr(2'd0); wd = 32'h55;
      repeat (3) tick();
      we = 1'b0;
      check("reset_tx", {31'h0, tx}, 32'h1);
      check("reset_rd", rd, 32'h0);
      reset = 1'b1;
      rd_reg(2'd1); check("reset_status", rd, 32'h2);
      rd_reg(2'd2); check("reset_div", rd, 32'd16);
      rd_reg(2'd0); check("data_reads_zero", rd, 32'h0);

      // Single frame 0xA5 at 4 cycles per bit.
      wr(2'd2, 32'd4);
      wr(2'd0, 32'hA5);
      set_addr(2'd3);
      tick();
      pat = {1'b1, 8'hA5, 1'b0};
      for (int i = 0; i < 40; i++) begin
         check("a5_tx", {31'h0, tx}, {31'h0, pat[i/4]});
         tick();
      end
      rd_reg(2'd1); check("a5_done_status", rd, 32'h2);

      // Overrun: nine bytes fill the FIFO (first is popped at once), tenth is dropped.
      wr(2'd2, 32'd100);
      for (int i = 0; i < 9; i++) wr(2'd0, 32'h10 + 32'(i));
      rd_reg(2'd1); check("ovr_full_status", rd, 32'h805);
      wr(2'd0, 32'hEE);
      rd_reg(2'd1); check("ovr_set_status", rd, 32'h80D);
      wr(2'd3, 32'hFFFF_FFFF);
      rd_reg(2'd1); check("rsvd_write_ignored", rd, 32'h80D);
      wr(2'd1, 32'h8);
      rd_reg(2'd1); check("ovr_clear_status", rd, 32'h805);
      reset = 1'b0; tick(); reset = 1'b1;
      check("ovr_reset_tx", {31'h0, tx}, 32'h1);

      // Back-to-back frames 0x00 then 0xFF at 2 cycles per bit.
      wr(2'd2, 32'd2);
      wr(2'd0, 32'h00);
      wr(2'd0, 32'hFF);
      pat2 = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
      for (int i = 0; i < 40; i++) begin
         check("b2b_tx", {31'h0, tx}, {31'h0, pat2[i/2]});
         tick();
      end
      repeat (4) tick();

      // Divisor 0 reads back as 1; a mid-frame divisor change affects only the next frame.
      wr(2'd2, 32'h0);
      rd_reg(2'd2); check("div_zero_is_one", rd, 32'h1);
      wr(2'd2, 32'd4);
      wr(2'd0, 32'h3C);
      repeat (5) tick();
      wr(2'd2, 32'd8);
      wr(2'd0, 32'h5A);
      repeat (130) tick();
      rd_reg(2'd2); check("div_mid_frame", rd, 32'd8);

      // Reset during data bit 3 with three bytes still queued.
      wr(2'd2, 32'd4);
      for (int i = 0; i < 4; i++) wr(2'd0, 32'hC0 + 32'(i));
      repeat (15) tick();
      reset = 1'b0; tick(); reset = 1'b1;
      check("midframe_reset_tx", {31'h0, tx}, 32'h1);
      rd_reg(2'd1); check("midframe_reset_status", rd, 32'h2);
      for (int i = 0; i < 60; i++) begin
         tick();
         check("no_frame_after_reset", {31'h0, tx}, 32'h1);
      end

      // Random bus traffic with occasional resets.
      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 299) != 0);
         we    = ($urandom_range(0, 2) == 0);
         rsel  = 2'($urandom_range(0, 3));
         set_addr(rsel);
         wd = $urandom();
         if (rsel == 2'd2) wd[15:0] = 16'($urandom_range(0, 3));
         tick();
      end
      reset = 1'b1;
      we    = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
